// File: rtl/mmio_fabric.sv
// mmio_fabric: registered memory-mapped interconnect between the core data port
// and NUM_SLAVES peripherals. It decodes addresses with per-slave mask/base pairs
// and runs one req/ack transaction at a time. A slave that never acks causes a
// timeout. Decode misses and timeouts are captured in sticky error registers.
module mmio_fabric #(
   parameter int NUM_SLAVES = 6,
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE = {32'h0000_1400, 32'h0000_1000,
                                                  32'h0000_0C00, 32'h0000_0800,
                                                  32'h0000_0400, 32'h0000_0000},
   parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK = {6{32'hFFFF_FF00}},
   parameter int TIMEOUT    = 16,
   parameter int ERRW       = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     m_req,
   input  logic                     m_we,
   input  logic [AW-1:0]            m_addr,
   input  logic [DW-1:0]            m_wdata,
   output logic [DW-1:0]            m_rdata,
   output logic                     m_ack,
   output logic                     m_err,
   output logic [NUM_SLAVES-1:0]    s_req,
   output logic                     s_we,
   output logic [AW-1:0]            s_addr,
   output logic [DW-1:0]            s_wdata,
   input  logic [NUM_SLAVES*DW-1:0] s_rdata,
   input  logic [NUM_SLAVES-1:0]    s_ack,
   input  logic                     err_clr,
   output logic [AW-1:0]            err_addr,
   output logic [1:0]               err_code,
   output logic [ERRW-1:0]          err_count
);

   localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [1:0] CODE_NONE = 2'b00;
   localparam logic [1:0] CODE_MISS = 2'b01;
   localparam logic [1:0] CODE_TOUT = 2'b10;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                state_q;
   logic [NUM_SLAVES-1:0] s_req_q;
   logic                  m_ack_q, m_err_q, s_we_q;
   logic [DW-1:0]         m_rdata_q, s_wdata_q;
   logic [AW-1:0]         s_addr_q;
   logic [SW-1:0]         sel_q;
   logic [TW-1:0]         cnt_q;

   logic [AW-1:0]         err_addr_q, err_addr_d;
   logic [1:0]            err_code_q, err_code_d;
   logic [ERRW-1:0]       err_count_q, err_count_d;

   logic                  dec_hit;
   logic [SW-1:0]         dec_idx;
   logic                  ack_sel;
   logic [DW-1:0]         rdata_sel;
   logic                  miss_fire, ack_fire, tout_fire;

   // Address decode: scan from the top so the lowest matching index is left standing.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((m_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
            dec_hit = 1'b1;
            dec_idx = SW'(i);
         end
      end
   end

   // Pick ack and read data of the latched slave; other slaves' strobes are ignored.
   always_comb begin
      ack_sel   = 1'b0;
      rdata_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q == SW'(i)) begin
            ack_sel   = s_ack[i];
            rdata_sel = s_rdata[i*DW +: DW];
         end
      end
   end

   // Transaction outcome events; an ack on the last allowed cycle beats the timeout.
   always_comb begin
      miss_fire = (state_q == IDLE) && m_req && !dec_hit;
      ack_fire  = (state_q == ACCESS) && ack_sel;
      tout_fire = (state_q == ACCESS) && !ack_sel && (TIMEOUT > 0) && (cnt_q == TO_LAST);
   end

   // Main transaction FSM with registered master and slave side outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         s_req_q   <= '0;
         m_ack_q   <= 1'b0;
         m_err_q   <= 1'b0;
         m_rdata_q <= '0;
         s_we_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
      end else begin
         m_ack_q <= 1'b0;
         m_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (m_req) begin
                  s_we_q    <= m_we;
                  s_addr_q  <= m_addr;
                  s_wdata_q <= m_wdata;
                  cnt_q     <= '0;
                  if (dec_hit) begin
                     sel_q   <= dec_idx;
                     s_req_q <= NUM_SLAVES'(1) << dec_idx;
                     state_q <= ACCESS;
                  end else begin
                     m_ack_q   <= 1'b1;
                     m_err_q   <= 1'b1;
                     m_rdata_q <= '0;
                     state_q   <= RESP;
                  end
               end
            end
            ACCESS: begin
               if (ack_fire) begin
                  s_req_q   <= '0;
                  m_ack_q   <= 1'b1;
                  m_rdata_q <= s_we_q ? '0 : rdata_sel;
                  state_q   <= RESP;
               end else if (tout_fire) begin
                  s_req_q   <= '0;
                  m_ack_q   <= 1'b1;
                  m_err_q   <= 1'b1;
                  m_rdata_q <= '0;
                  state_q   <= RESP;
               end else begin
                  cnt_q <= cnt_q + TW'(1);
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Error capture next state: a new error overrides a simultaneous clear.
   always_comb begin
      err_addr_d  = err_addr_q;
      err_code_d  = err_code_q;
      err_count_d = err_count_q;
      if (miss_fire || tout_fire) begin
         err_addr_d = miss_fire ? m_addr : s_addr_q;
         err_code_d = miss_fire ? CODE_MISS : CODE_TOUT;
         if (err_clr) begin
            err_count_d = ERRW'(1);
         end else if (err_count_q != {ERRW{1'b1}}) begin
            err_count_d = err_count_q + ERRW'(1);
         end
      end else if (err_clr) begin
         err_code_d  = CODE_NONE;
         err_count_d = '0;
      end
   end

   // Sticky error registers, updated on the edge that launches the errored response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_addr_q  <= '0;
         err_code_q  <= CODE_NONE;
         err_count_q <= '0;
      end else begin
         err_addr_q  <= err_addr_d;
         err_code_q  <= err_code_d;
         err_count_q <= err_count_d;
      end
   end

   assign m_rdata   = m_rdata_q;
   assign m_ack     = m_ack_q;
   assign m_err     = m_err_q;
   assign s_req     = s_req_q;
   assign s_we      = s_we_q;
   assign s_addr    = s_addr_q;
   assign s_wdata   = s_wdata_q;
   assign err_addr  = err_addr_q;
   assign err_code  = err_code_q;
   assign err_count = err_count_q;

endmodule

// File: doc/mmio_fabric.md
Name: mmio_fabric

Overview:
- Parametrised, registered memory-mapped interconnect between the MIPS core data port and NUM_SLAVES peripherals (data memory, interrupt controller, factorial units, future accelerators).
- Replaces the fixed six-way combinational decode with mask/base address decoding and a per-access req/ack handshake.
- Adds a slave timeout and a sticky bus-error capture block.
- At most one transaction is outstanding at a time.

Parameters:
NUM_SLAVES, 6, number of slave ports (1..16)
AW, 32, address width
DW, 32, data width
SLV_BASE, {6 regions, 32 bits each}, packed NUM_SLAVES*AW base addresses; slave i occupies bits [i*AW +: AW]
SLV_MASK, {6 regions, 32 bits each}, packed NUM_SLAVES*AW masks; slave i hits when (m_addr & mask_i) == base_i
TIMEOUT, 16, maximum cycles in ACCESS before a bus error; 0 disables the timeout
ERRW, 8, width of the saturating error counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
m_req  in  1  master request; held stable with m_we/m_addr/m_wdata until m_ack
m_we  in  1  1 = write, 0 = read
m_addr  in  AW  access address
m_wdata  in  DW  write data
m_rdata  out  DW  read data, valid while m_ack is high
m_ack  out  1  one-cycle response strobe
m_err  out  1  error qualifier, valid with m_ack
s_req  out  NUM_SLAVES  one-hot request to the selected slave
s_we  out  1  registered write enable, shared by all slaves
s_addr  out  AW  registered address, shared by all slaves
s_wdata  out  DW  registered write data, shared by all slaves
s_rdata  in  NUM_SLAVES*DW  packed read data; slave i at [i*DW +: DW]
s_ack  in  NUM_SLAVES  per-slave completion; sampled only for the selected slave
err_clr  in  1  clears err_count and err_code
err_addr  out  AW  address of the most recent failed access
err_code  out  2  cause of the last error: 00 none, 01 decode miss, 10 timeout
err_count  out  ERRW  saturating count of errors

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs are 0: s_req, m_ack, m_err, m_rdata, s_we, s_addr, s_wdata, err_addr, err_code, err_count.
  - The timeout counter is 0.
- Decode:
  - Combinational from m_addr.
  - The lowest index wins if regions overlap.
  - No hit is a miss.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On m_req=1, register m_we, m_addr and m_wdata into s_*.
  - Hit: go to ACCESS and latch sel_idx.
  - Miss: go to RESP with err=1, code=01.
  - m_req=0: stay in IDLE.
- ACCESS:
  - s_req[sel_idx]=1; all other s_req bits are 0.
  - The counter increments each cycle.
  - s_ack[sel_idx]=1: latch s_rdata[sel_idx] (reads only; writes latch 0), go to RESP with err=0.
  - Counter reaches TIMEOUT-1 with no ack (TIMEOUT>0): go to RESP with err=1, code=10, m_rdata=0.
  - Ack and timeout in the same cycle: the ack wins.
  - s_ack on non-selected slaves is ignored.
- RESP:
  - m_ack=1 for exactly one cycle; m_err reflects the error flag.
  - s_req=0.
  - Always return to IDLE, regardless of m_req.
- Latency, edges counted from the first edge sampling m_req:
  - Miss: m_ack high after 1 edge.
  - Hit with the slave acking on the first s_req cycle: m_ack high after 2 edges.
  - Timeout: m_ack high after TIMEOUT+1 edges.
  - Back-to-back throughput: 1 access per 3 cycles minimum.
- Data holding:
  - m_rdata holds its value until the next RESP.
  - s_addr, s_wdata and s_we hold their values until the next accepted request.
- Late acks: an s_ack arriving after a timeout, in RESP or IDLE, is ignored.
- Error capture:
  - Any errored RESP loads err_addr=s_addr and err_code.
  - The same event increments err_count, saturating at 2^ERRW-1.
  - err_clr zeroes err_count and err_code; err_addr is retained.
  - err_clr in the same cycle as an error: the error wins, giving err_count=1 and the new code.
- Reset mid-ACCESS: s_req drops immediately (async); no m_ack is produced for the aborted access.
- Writes to a slave complete only on that slave's s_ack; the fabric never generates writes itself.

Test Plan:
- Read, default map, slave 2 at base 0x0000_0800 mask 0xFFFF_FF00; m_addr=0x804; slave acks on the first s_req cycle with 0xDEAD_BEEF -> s_req=6'b000100 for 1 cycle, m_ack 2 edges after the request, m_rdata=0xDEAD_BEEF, m_err=0.
- Write to slave 0, m_addr=0x10, m_wdata=0x1234, slave acks after 3 cycles -> s_we=1, s_wdata=0x1234, s_req[0] high 4 cycles, single m_ack, m_err=0, err_count=0.
- Unmapped m_addr=0xFFFF_0000 -> m_ack after 1 edge, m_err=1, s_req never asserted, err_code=01, err_addr=0xFFFF_0000, err_count=1.
- Slave 4 never acks, TIMEOUT=16 -> s_req[4] high 16 cycles, then m_ack with m_err=1, err_code=10, m_rdata=0; a late s_ack[4] two cycles later is ignored.
- Ack on the exact timeout cycle -> m_err=0 and data returned; err_clr asserted in the same cycle as a decode miss -> err_count=1, err_code=01.
- rst pulsed mid-ACCESS -> s_req=0 immediately, no m_ack; a following request completes normally; 300 forced errors with ERRW=8 -> err_count saturates at 255.
